// File: rtl/regfile_pkg.sv
// Shared limits, defaults and address-width helper for the multi-port register file.
package regfile_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 32;
    localparam int WIDTH_MAX     = 64;
    localparam int DEPTH_MIN     = 2;
    localparam int DEPTH_MAX     = 64;
    localparam int NUM_READ_MAX  = 4;
    localparam int NUM_WRITE_MAX = 2;

    function automatic int calc_aw(input int depth);
        int aw;
        aw = 0;
        while ((1 << aw) < depth) begin
            aw++;
        end
        return (aw < 1) ? 1 : aw;
    endfunction

endpackage

// File: rtl/regfile_readport.sv
// One registered read port: DEPTH:1 select, write-first bypass and output/valid registers.
module regfile_readport
    import regfile_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [WIDTH-1:0]          regs_i [DEPTH],
    input  logic [NUM_WRITE-1:0]      wr_en_i,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr_i,
    input  logic [NUM_WRITE*WIDTH-1:0] wr_data_i,
    input  logic                      rd_en_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic [WIDTH-1:0]          rd_data_o,
    output logic                      rd_valid_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Later write ports override earlier ones, so port 1 wins a bypass conflict.
    always_comb begin
        data_d = regs_i[rd_addr_i];
        for (int p = 0; p < NUM_WRITE; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
                data_d = wr_data_i[p*WIDTH +: WIDTH];
            end
        end
        if ((ZERO_REG0 != 0) && (rd_addr_i == '0)) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_i;
            if (rd_en_i) begin
                data_q <= data_d;
            end
        end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_WRITE write ports, NUM_READ registered write-first read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic [NUM_WRITE-1:0]       ctrl_writeEnable,
    input  logic [NUM_WRITE*AW-1:0]    ctrl_writeReg,
    input  logic [NUM_WRITE*WIDTH-1:0] data_writeReg,
    input  logic [NUM_READ-1:0]        ctrl_readEnable,
    input  logic [NUM_READ*AW-1:0]     ctrl_readReg,
    output logic [NUM_READ*WIDTH-1:0]  data_readReg,
    output logic [NUM_READ-1:0]        data_readValid
);

    if ((WIDTH < 1) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $fatal(1, "regfile_mp: WIDTH out of range");
    end
    if ((DEPTH < DEPTH_MIN) || (DEPTH > DEPTH_MAX) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "regfile_mp: DEPTH must be a power of two in range");
    end
    if ((NUM_READ < 1) || (NUM_READ > NUM_READ_MAX)) begin : g_bad_nread
        $fatal(1, "regfile_mp: NUM_READ out of range");
    end
    if ((NUM_WRITE < 1) || (NUM_WRITE > NUM_WRITE_MAX)) begin : g_bad_nwrite
        $fatal(1, "regfile_mp: NUM_WRITE out of range");
    end

    logic [WIDTH-1:0] regs_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        logic [WIDTH-1:0] reg_d;

        // Scan ports in ascending order so port 1 wins a same-address conflict.
        always_comb begin
            reg_d = regs_q[gi];
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (ctrl_writeEnable[p] && (ctrl_writeReg[p*AW +: AW] == AW'(gi))) begin
                    reg_d = data_writeReg[p*WIDTH +: WIDTH];
                end
            end
            if ((ZERO_REG0 != 0) && (gi == 0)) begin
                reg_d = '0;
            end
        end

        always_ff @(posedge clock) begin
            if (ctrl_reset) begin
                regs_q[gi] <= '0;
            end else begin
                regs_q[gi] <= reg_d;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        regfile_readport #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .NUM_WRITE (NUM_WRITE),
            .ZERO_REG0 (ZERO_REG0)
        ) u_port (
            .clk_i      (clock),
            .srst_i     (ctrl_reset),
            .regs_i     (regs_q),
            .wr_en_i    (ctrl_writeEnable),
            .wr_addr_i  (ctrl_writeReg),
            .wr_data_i  (data_writeReg),
            .rd_en_i    (ctrl_readEnable[gi]),
            .rd_addr_i  (ctrl_readReg[gi*AW +: AW]),
            .rd_data_o  (data_readReg[gi*WIDTH +: WIDTH]),
            .rd_valid_o (data_readValid[gi])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against a write-first array model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [1:0]  re;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rv;

    // Second instance with register 0 writable, one read and one write port.
    logic        nz_we;
    logic [4:0]  nz_wa;
    logic [31:0] nz_wd;
    logic        nz_re;
    logic [4:0]  nz_ra;
    logic [31:0] nz_rd;
    logic        nz_rv;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem    [32];
    logic [31:0] mem_nz [32];
    logic [31:0] exp_d  [2];
    logic        exp_v  [2];
    logic [31:0] nz_exp_d;
    logic        nz_exp_v;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clock            (clk),
        .ctrl_reset       (rst),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wa),
        .data_writeReg    (wd),
        .ctrl_readEnable  (re),
        .ctrl_readReg     (ra),
        .data_readReg     (rd),
        .data_readValid   (rv)
    );

    regfile_mp #(.NUM_READ(1), .NUM_WRITE(1), .ZERO_REG0(0)) u_dut_nz (
        .clock            (clk),
        .ctrl_reset       (rst),
        .ctrl_writeEnable (nz_we),
        .ctrl_writeReg    (nz_wa),
        .data_writeReg    (nz_wd),
        .ctrl_readEnable  (nz_re),
        .ctrl_readReg     (nz_ra),
        .data_readReg     (nz_rd),
        .data_readValid   (nz_rv)
    );

    task automatic idle();
        we = '0; wa = '0; wd = '0; re = '0; ra = '0;
        nz_we = 1'b0; nz_wa = '0; nz_wd = '0; nz_re = 1'b0; nz_ra = '0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p] = 1'b1;
        wa[p*5 +: 5] = a;
        wd[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        re[p] = 1'b1;
        ra[p*5 +: 5] = a;
    endtask

    // Advance one edge, updating the model from the inputs currently driven.
    task automatic tick();
        logic [4:0] a;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] = '0;
                mem_nz[i] = '0;
            end
            for (int r = 0; r < 2; r++) begin
                exp_d[r] = '0;
                exp_v[r] = 1'b0;
            end
            nz_exp_d = '0;
            nz_exp_v = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = wa[p*5 +: 5];
                if (we[p] && a != 5'd0) mem[a] = wd[p*32 +: 32];
            end
            for (int r = 0; r < 2; r++) begin
                a = ra[r*5 +: 5];
                exp_v[r] = re[r];
                if (re[r]) exp_d[r] = (a == 5'd0) ? 32'd0 : mem[a];
            end
            if (nz_we) mem_nz[nz_wa] = nz_wd;
            nz_exp_v = nz_re;
            if (nz_re) nz_exp_d = mem_nz[nz_ra];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (rd !== 64'd0 || rv !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_out: data=%h valid=%b required data=0 valid=00", rd, rv);
        end
        for (int a = 0; a < 32; a++) begin
            idle();
            set_rd(0, 5'(a));
            set_rd(1, 5'(31 - a));
            tick();
            n_cmp++;
            if (rd !== 64'd0 || rv !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_zero_read a=%0d: data=%h valid=%b required 0 / 11", a, rd, rv);
            end
        end
        idle();
        tick();
        n_cmp++;
        if (rv !== 2'b00 || rd !== 64'd0) begin
            n_fail++;
            $display("FAIL valid_one_cycle: valid=%b data=%h required valid=00 data held 0", rv, rd);
        end
    endtask

    task automatic test_latency();
        idle();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        set_rd(1, 5'd5);
        tick();
        n_cmp++;
        if (rd[63:32] !== 32'hDEADBEEF || rv[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_r5: data=%h valid=%b required deadbeef/1", rd[63:32], rv[1]);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_wr(1, 5'd7, 32'h12345678);
        set_rd(0, 5'd7);
        tick();
        n_cmp++;
        if (rd[31:0] !== 32'h12345678 || rv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_r7: data=%h valid=%b required 12345678/1", rd[31:0], rv[0]);
        end
    endtask

    task automatic test_conflict();
        idle();
        set_wr(0, 5'd3, 32'h1);
        set_wr(1, 5'd3, 32'h2);
        set_rd(0, 5'd3);
        set_rd(1, 5'd3);
        tick();
        n_cmp++;
        if (rd !== {32'h2, 32'h2}) begin
            n_fail++;
            $display("FAIL conflict_bypass: data=%h required 0000000200000002", rd);
        end
        idle();
        set_rd(0, 5'd3);
        tick();
        n_cmp++;
        if (rd[31:0] !== 32'h2) begin
            n_fail++;
            $display("FAIL conflict_later: data=%h required 00000002", rd[31:0]);
        end
    endtask

    task automatic test_reg0();
        idle();
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        nz_we = 1'b1; nz_wa = 5'd0; nz_wd = 32'hFFFFFFFF;
        tick();
        idle();
        set_rd(0, 5'd0);
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        nz_re = 1'b1; nz_ra = 5'd0;
        tick();
        n_cmp++;
        if (rd[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL reg0_zero: data=%h required 00000000", rd[31:0]);
        end
        n_cmp++;
        if (nz_rd !== 32'hFFFFFFFF || nz_rv !== 1'b1) begin
            n_fail++;
            $display("FAIL reg0_writable: data=%h valid=%b required ffffffff/1", nz_rd, nz_rv);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_wr(p, 5'($urandom_range(0, (n % 2) ? 7 : 31)), $urandom);
                end
                if ($urandom_range(0, 3) != 0) begin
                    set_rd(p, 5'($urandom_range(0, (n % 2) ? 7 : 31)));
                end
            end
            nz_we = 1'($urandom_range(0, 1));
            nz_wa = 5'($urandom_range(0, 7));
            nz_wd = $urandom;
            nz_re = 1'($urandom_range(0, 1));
            nz_ra = 5'($urandom_range(0, 7));
            tick();
            for (int r = 0; r < 2; r++) begin
                n_cmp++;
                if (rd[r*32 +: 32] !== exp_d[r] || rv[r] !== exp_v[r]) begin
                    n_fail++;
                    $display("FAIL random n=%0d port=%0d: data=%h valid=%b required %h/%b",
                             n, r, rd[r*32 +: 32], rv[r], exp_d[r], exp_v[r]);
                end
            end
            n_cmp++;
            if (nz_rd !== nz_exp_d || nz_rv !== nz_exp_v) begin
                n_fail++;
                $display("FAIL random_nz n=%0d: data=%h valid=%b required %h/%b",
                         n, nz_rd, nz_rv, nz_exp_d, nz_exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int a = 1; a < 32; a += 2) begin
            idle();
            set_wr(0, 5'(a), 32'(a));
            if (a + 1 < 32) set_wr(1, 5'(a + 1), 32'(a + 1));
            tick();
        end
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd30);
        tick();
        n_cmp++;
        if (rd !== {32'd30, 32'd9}) begin
            n_fail++;
            $display("FAIL fill_check: data=%h required 0000001e00000009", rd);
        end
        set_wr(0, 5'd4, 32'hABCD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (rd !== 64'd0 || rv !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_out: data=%h valid=%b required 0/00", rd, rv);
        end
        for (int a = 0; a < 32; a++) begin
            idle();
            set_rd(0, 5'(a));
            set_rd(1, 5'(a));
            tick();
            n_cmp++;
            if (rd !== 64'd0 || rv !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_mid_read a=%0d: data=%h valid=%b required 0/11", a, rd, rv);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_latency();
        test_bypass();
        test_conflict();
        test_reg0();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; legal range 1 to 64.
REQ-002 Parameter DEPTH, default 32: number of registers; power of two, 2 to 64. Internally AW = log2(DEPTH).
REQ-003 Parameter NUM_READ, default 2: number of read ports; legal range 1 to 4.
REQ-004 Parameter NUM_WRITE, default 2: number of write ports; legal range 1 to 2.
REQ-005 Parameter ZERO_REG0, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-006 clock  in  1: the single clock; all state updates on its rising edge.
REQ-007 ctrl_reset  in  1: reset, synchronous and active-high.
REQ-008 ctrl_writeEnable  in  NUM_WRITE: per-port write strobe.
REQ-009 ctrl_writeReg  in  NUM_WRITE*AW: per-port write address; port p occupies bits [p*AW +: AW].
REQ-010 data_writeReg  in  NUM_WRITE*WIDTH: per-port write data, packed the same way.
REQ-011 ctrl_readEnable  in  NUM_READ: per-port read request.
REQ-012 ctrl_readReg  in  NUM_READ*AW: per-port read address, packed as in REQ-009.
REQ-013 data_readReg  out  NUM_READ*WIDTH: per-port registered read data.
REQ-014 data_readValid  out  NUM_READ: per-port flag; high for one cycle when data_readReg holds a result.

Function
REQ-015 Writes: each enabled write port updates its addressed register at the rising edge.
REQ-016 Write conflict: if both write ports target the same register in one cycle, port 1 wins.
REQ-017 Reads have 1-cycle latency: a request sampled at edge N appears on data_readReg and data_readValid after edge N; those outputs are stable until edge N+1.
REQ-018 If ctrl_readEnable[p]=0: data_readValid[p] goes low at the next edge and data_readReg[p] holds its previous value.
REQ-019 Bypass: if a read and an enabled write target the same register in the same cycle, the read returns the new write data (write-first).
REQ-020 Bypass conflicts follow REQ-016: port 1 data is returned.
REQ-021 With ZERO_REG0=1, a read of address 0 returns 0 and is never bypassed; writes to address 0 are discarded.
REQ-022 Read ports are independent: any number of ports may read the same address in the same cycle, and all receive identical data.
REQ-023 No storage beyond the DEPTH registers plus the read output registers; no X on outputs after reset.

Reset
REQ-024 While ctrl_reset=1 at an edge, the next state is: all registers 0, data_readReg all 0, data_readValid all 0. This applies to every port.
REQ-025 Reset overrides every write and read in the same cycle; there is no bypass of reset-cycle writes.
REQ-026 The first request sampled after reset deasserts returns its result at the following edge.

Structure
REQ-027 Shared package regfile_pkg holds WIDTH and DEPTH defaults, the NUM_READ and NUM_WRITE limits, and the AW derivation function.
REQ-028 One sub-module, regfile_readport, instantiated NUM_READ times. Each instance contains the DEPTH:1 WIDTH-bit select tree, the bypass compare, and the output and valid registers.
REQ-029 Parameter legality is checked at elaboration; illegal values are a fatal elaboration error.

Verification
REQ-030 Reset and zero-read: assert reset, then read all addresses on every port -> all data 0; valid high exactly one cycle after each request.
REQ-031 Write/read latency: write 0xDEADBEEF to r5 at edge N, read r5 at edge N+1 -> data_readReg 0xDEADBEEF after edge N+1.
REQ-032 Bypass: in the same cycle, write 0x12345678 to r7 and read r7 on port 0 (r7 previously 0) -> port 0 returns 0x12345678 after one edge.
REQ-033 Write conflict: port 0 writes 0x1, port 1 writes 0x2, both to r3, with a simultaneous read of r3 -> read returns 0x2; a later read also returns 0x2.
REQ-034 Register 0: write 0xFFFFFFFF to r0, then read r0 -> 0 with ZERO_REG0=1; 0xFFFFFFFF with ZERO_REG0=0.
REQ-035 Reset mid-operation: fill r1 to r31 with their own index, assert reset during active reads -> next outputs 0, valid 0; all registers read 0 afterwards.
